// File: rtl/mem_data_access.sv
// MEM-stage data-bus access controller: request/addr_ok/data_ok handshake, load capture, stall and irq drain.
// Optional WAIT/CANCEL watchdog enabled by defining MEM_DATA_ACCESS_TIMEOUT_EN.
module mem_data_access #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        mem_we,
  input  logic        irq,
  input  logic [31:0] ALU_result,
  input  logic [3:0]  byte_valid,
  input  logic [31:0] store_data,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] mem_rdata,
  output logic        stall0,
  output logic        bus_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_CANCEL = 3'd4;

  logic [2:0] state, state_nx;
  logic [1:0] req_size;
  logic       start;
  logic       expire;

  assign start = mem_en & ~irq;

  always_comb begin
    req_size = 2'd2;
    case (byte_valid)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: req_size = 2'd0;
      4'b0011, 4'b1100:                   req_size = 2'd1;
      default:                            req_size = 2'd2;
    endcase
  end

`ifdef MEM_DATA_ACCESS_TIMEOUT_EN
  logic [CNT_W-1:0] wd_cnt;

  // An irq in WAIT takes the CANCEL path, so expiry there only counts without irq.
  assign expire = ((state == S_WAIT && !irq) || state == S_CANCEL) && !data_data_ok &&
                  (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst)
      wd_cnt <= '0;
    else if ((state_nx == S_WAIT || state_nx == S_CANCEL) && state_nx != state)
      wd_cnt <= '0;
    else if (state == S_WAIT || state == S_CANCEL)
      wd_cnt <= wd_cnt + 1'b1;
  end
`else
  logic [31:0] unused_cfg;
  assign unused_cfg = TIMEOUT_CYCLES ^ CNT_W;
  assign expire     = 1'b0;
`endif

  assign bus_err  = expire;
  assign data_req = (state == S_REQ);
  // First MEM cycle already stalls, so the instruction never slips past an access.
  assign stall0   = (state == S_IDLE) ? start : (state != S_DONE);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_REQ;
      S_REQ: begin
        if (data_addr_ok) state_nx = irq ? S_CANCEL : S_WAIT;
        else if (irq)     state_nx = S_IDLE;
      end
      S_WAIT: begin
        if (data_data_ok) state_nx = irq ? S_IDLE : S_DONE;
        else if (irq)     state_nx = S_CANCEL;
        else if (expire)  state_nx = S_DONE;
      end
      S_DONE:   state_nx = S_IDLE;
      S_CANCEL: if (data_data_ok || expire) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      data_wr    <= 1'b0;
      data_size  <= 2'd0;
      data_addr  <= 32'h0;
      data_wstrb <= 4'h0;
      data_wdata <= 32'h0;
      mem_rdata  <= 32'h0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && start) begin
        data_wr    <= mem_we;
        data_size  <= req_size;
        data_addr  <= (req_size == 2'd2) ? {ALU_result[31:2], 2'b00} : ALU_result;
        data_wstrb <= mem_we ? byte_valid : 4'h0;
        data_wdata <= store_data;
      end
      if (state == S_WAIT && !data_wr) begin
        if (data_data_ok && !irq) mem_rdata <= data_rdata;
        else if (expire)          mem_rdata <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_mem_data_access.sv
// Randomized bench for mem_data_access with a transaction-level bus/pipeline model.
module tb_mem_data_access;
`ifdef MEM_DATA_ACCESS_TIMEOUT_EN
  localparam int TOC = 8;
  localparam int CW  = 4;
`else
  localparam int TOC = 256;
  localparam int CW  = 9;
`endif

  logic        clk = 1'b0;
  logic        rst, mem_en, mem_we, irq;
  logic [31:0] ALU_result, store_data, data_rdata;
  logic [3:0]  byte_valid;
  logic        data_addr_ok, data_data_ok;
  logic        data_req, data_wr, stall0, bus_err;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, mem_rdata;
  logic [3:0]  data_wstrb;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_rdata = 32'h0;
  logic [3:0]  bv_tab [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

  always #5 clk = ~clk;

  mem_data_access #(.TIMEOUT_CYCLES(TOC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_we(mem_we), .irq(irq),
    .ALU_result(ALU_result), .byte_valid(byte_valid), .store_data(store_data),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata), .mem_rdata(mem_rdata),
    .stall0(stall0), .bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_req", data_req, 0);     chk("rst_wr", data_wr, 0);
    chk("rst_stall", stall0, 0);     chk("rst_err", bus_err, 0);
    chk("rst_size", data_size, 0);   chk("rst_addr", data_addr, 0);
    chk("rst_wstrb", data_wstrb, 0); chk("rst_wdata", data_wdata, 0);
    chk("rst_rdata", mem_rdata, 0);
  endtask

  // Idle pipeline cycles; any irq-flushed mem_en must not start an access.
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      mem_en = 1'($urandom); irq = mem_en ? 1'b1 : 1'($urandom);
      data_addr_ok = 1'($urandom); data_data_ok = 1'($urandom); data_rdata = $urandom;
      @(negedge clk);
      chk("idle_stall", stall0, 0); chk("idle_req", data_req, 0);
      tick();
    end
    mem_en = 0; irq = 0;
  endtask

  // mode: 0 normal, 1 irq in REQ before addr_ok, 2 irq with addr_ok,
  //       3 irq in first WAIT cycle before data_ok, 4 irq with data_ok
  task automatic access(input bit we, input logic [31:0] addr, input logic [3:0] bv,
                        input logic [31:0] wd, input logic [31:0] rd,
                        input int adly, input int ddly, input int mode);
    logic [1:0]  esz;
    logic [31:0] ea;
    bit cancel, flushed;
    esz = ($countones(bv) == 1) ? 2'd0 : (bv == 4'b0011 || bv == 4'b1100) ? 2'd1 : 2'd2;
    ea  = (esz == 2'd2) ? (addr & 32'hFFFF_FFFC) : addr;
    mem_en = 1; mem_we = we; ALU_result = addr; byte_valid = bv; store_data = wd; irq = 0;
    data_addr_ok = 1'($urandom); data_data_ok = 1'($urandom); data_rdata = $urandom;
    @(negedge clk);
    chk("first_stall", stall0, 1); chk("first_req", data_req, 0);
    tick();
    for (int i = 0; i <= adly; i++) begin
      data_addr_ok = (i == adly);
      irq = (mode == 1 && i == 0) || (mode == 2 && i == adly);
      data_data_ok = 1'($urandom); data_rdata = $urandom;
      @(negedge clk);
      chk("req_req", data_req, 1);    chk("req_stall", stall0, 1);
      chk("req_addr", data_addr, ea); chk("req_size", data_size, esz);
      chk("req_wr", data_wr, we);     chk("req_wstrb", data_wstrb, we ? bv : 4'h0);
      chk("req_wdata", data_wdata, wd);
      tick();
      if (mode == 1 && i == 0) begin
        mem_en = 0; irq = 0; data_addr_ok = 0; data_data_ok = 0;
        @(negedge clk);
        chk("flush_req", data_req, 0); chk("flush_stall", stall0, 0);
        chk("flush_rdata", mem_rdata, exp_rdata);
        tick();
        return;
      end
    end
    cancel = (mode == 2); flushed = 0;
    for (int j = 0; j <= ddly; j++) begin
      data_addr_ok = 1'($urandom);
      data_data_ok = (j == ddly);
      data_rdata = (j == ddly) ? rd : $urandom;
      if (cancel) irq = 1'($urandom);
      else irq = (mode == 3 && j == 0) || (mode == 4 && j == ddly);
      @(negedge clk);
      chk("wait_stall", stall0, 1); chk("wait_req", data_req, 0);
      chk("wait_err", bus_err, 0);
      if (!cancel && irq && !data_data_ok) cancel = 1;
      if (!cancel && irq && data_data_ok) flushed = 1;
      tick();
    end
    irq = 0;
    if (cancel || flushed) begin
      mem_en = 0; data_data_ok = 0; data_addr_ok = 0;
      @(negedge clk);
      chk("drain_stall", stall0, 0); chk("drain_req", data_req, 0);
      chk("drain_rdata", mem_rdata, exp_rdata);
      tick();
    end else begin
      if (!we) exp_rdata = rd;
      data_addr_ok = 1'($urandom); data_data_ok = 1'($urandom); data_rdata = $urandom;
      @(negedge clk);
      chk("done_stall", stall0, 0); chk("done_req", data_req, 0);
      chk("done_rdata", mem_rdata, exp_rdata);
      tick();
      mem_en = 0;
    end
  endtask

  initial begin
    rst = 1; mem_en = 0; mem_we = 0; irq = 0; ALU_result = 0; byte_valid = 0;
    store_data = 0; data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
    repeat (3) tick();
    @(negedge clk);
    chk_reset_vals();
    tick();
    rst = 0;

    access(0, 32'h1000_0006, 4'b1111, 32'h0, 32'hCAFE_BABE, 0, 0, 0);
    idle(2);
    access(1, 32'h0000_2002, 4'b1100, 32'hBEEF_0000, 32'h5555_5555, 3, 1, 0);
    idle(1);
    access(0, 32'h0000_3000, 4'b1111, 32'h0, 32'hAAAA_AAAA, 2, 0, 1);
    idle(1);
    access(0, 32'h0000_4000, 4'b1111, 32'h0, 32'h1234_5678, 0, 5, 3);
    access(0, 32'h0000_5001, 4'b0001, 32'h0, 32'h0000_0011, 0, 0, 0);
    access(0, 32'h0000_5003, 4'b1000, 32'h0, 32'h2200_0000, 0, 0, 0);
    access(0, 32'h0000_6000, 4'b1111, 32'h0, 32'h6666_6666, 1, 2, 2);
    access(0, 32'h0000_7000, 4'b1111, 32'h0, 32'h7777_7777, 0, 3, 4);

    for (int t = 0; t < 60; t++) begin
      int adly, ddly, mode;
      adly = $urandom_range(0, 3); ddly = $urandom_range(0, 4); mode = $urandom_range(0, 6);
      if (mode > 4) mode = 0;
      if (mode == 1 && adly == 0) adly = 1;
      if (mode == 3 && ddly == 0) ddly = 1;
      access(1'($urandom), $urandom, bv_tab[$urandom_range(0, 6)], $urandom, $urandom,
             adly, ddly, mode);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end

`ifdef MEM_DATA_ACCESS_TIMEOUT_EN
    access(0, 32'h0000_8000, 4'b1111, 32'h0, 32'h8888_8888, 0, 0, 0);
    mem_en = 1; mem_we = 0; ALU_result = 32'h0000_9000; byte_valid = 4'b1111; irq = 0;
    data_addr_ok = 0; data_data_ok = 0;
    tick();
    data_addr_ok = 1;
    tick();
    data_addr_ok = 0;
    for (int j = 0; j < TOC; j++) begin
      @(negedge clk);
      chk("to_stall", stall0, 1); chk("to_err", bus_err, (j == TOC - 1) ? 1 : 0);
      tick();
    end
    exp_rdata = 32'h0;
    @(negedge clk);
    chk("to_done_stall", stall0, 0); chk("to_done_err", bus_err, 0);
    chk("to_done_rdata", mem_rdata, exp_rdata);
    tick();
    mem_en = 0;
    idle(1);
`endif

    access(0, 32'h0000_A004, 4'b1111, 32'h0, 32'hA5A5_A5A5, 0, 0, 0);
    mem_en = 1; mem_we = 1; ALU_result = 32'h0000_B008; byte_valid = 4'b1111;
    store_data = 32'hDEAD_BEEF; irq = 0; data_addr_ok = 0; data_data_ok = 0;
    tick();
    data_addr_ok = 1;
    tick();
    data_addr_ok = 0; rst = 1;
    tick();
    rst = 0; mem_en = 0; exp_rdata = 32'h0;
    @(negedge clk);
    chk_reset_vals();
    tick();
    access(0, 32'h0000_C000, 4'b1111, 32'h0, 32'hC0C0_C0C0, 1, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
